ascii_byte_parser: RTL and testbench
====================================

# ascii_byte_parser

Receive-side counterpart of the LCD hex/decimal row formatter. Consumes an ASCII character stream (one byte per `i_rxValid` strobe, typically from the UART receiver) and parses a decimal number (`"0"`..`"255"`) or an `x`-prefixed hex number (`"x0"`..`"xFF"`) into an 8-bit value. The result is delivered as a single-cycle strobe. It sits between the UART RX and any register or LCD logic that takes a byte from the operator.

## Interface
- `ACCEPT_SPACE`, default 1: when 1, space (0x20) is a terminator in addition to CR (0x0D) and LF (0x0A). When 0, space is an invalid character.
- `i_clk` input 1: the single clock; all logic is on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_rxValid` input 1: qualifies `i_rxByte` for one cycle. May be high on consecutive cycles.
- `i_rxByte` input 8: ASCII character.
- `o_value` output 8: last successfully parsed value. Held until the next success.
- `o_valid` output 1: one-cycle pulse; `o_value` is updated in the same cycle.
- `o_error` output 1: one-cycle pulse on a rejected token.
- `o_busy` output 1: high while a token is in progress (state ≠ IDLE).

## Operation
- Internal state:
  - FSM with states IDLE, DEC, HEX, ERR.
  - 10-bit accumulator `acc`.
  - 2-bit digit counter `cnt`.
- Character classes:
  - dec digit: 0x30–0x39.
  - hex digit: dec digit, plus 0x41–0x46 and 0x61–0x66 (case-insensitive).
  - prefix: 'x' or 'X'.
  - terminator: CR, LF, and space if `ACCEPT_SPACE`.
  - anything else is invalid.
- Cycles with `i_rxValid`=0 change nothing.
- IDLE:
  - dec digit → `acc`=d, `cnt`=1, go to DEC.
  - prefix → `acc`=0, `cnt`=0, go to HEX.
  - terminator → ignored; stay in IDLE with no pulse. Blank lines and CRLF pairs are silent.
  - invalid → go to ERR.
- DEC:
  - dec digit: compute `acc*10+d` at 10-bit width. If `cnt`==3 or the result is >255, go to ERR. Otherwise store it and increment `cnt`.
  - terminator → `o_value`=`acc[7:0]`, pulse `o_valid`, go to IDLE.
  - prefix or other character → go to ERR.
  - Leading zeros count as digits: "007" is valid (7); "0007" is an error.
- HEX:
  - hex digit: if `cnt`==2, go to ERR. Otherwise `acc`=`{acc[3:0],nibble}` and increment `cnt`.
  - terminator: if `cnt`==0, pulse `o_error` and go to IDLE (a bare "x" is an error). Otherwise update `o_value`, pulse `o_valid`, go to IDLE.
  - other character → go to ERR.
- ERR: discard characters until a terminator arrives. On the terminator, pulse `o_error` and go to IDLE. Exactly one `o_error` is raised per bad token, at its terminator.
- `o_valid` and `o_error` are never high together.

## Timing
- All outputs are registered.
- The `o_valid`/`o_error` pulse appears in the cycle after the clock edge that samples the terminator with `i_rxValid`=1. Latency is 1 cycle.
- Back-to-back tokens are supported at full rate. A digit in the cycle right after a terminator starts a new token with no gap required.
- `o_busy` is a registered decode of the state. It rises the cycle after the first accepted non-terminator character and falls with the completing pulse.
- Reset values: state=IDLE, `acc`=0, `cnt`=0, `o_value`=0x00, `o_valid`=0, `o_error`=0, `o_busy`=0.
- Reset asserted mid-token aborts it: no pulse, and all partial digits are lost. Reset has priority over `i_rxValid` in the same cycle.
- There is no backpressure. The block must accept a character on every valid cycle.

## Test plan
- Decimal: "1","2","8",CR, sent back-to-back → one `o_valid` pulse 1 cycle after CR, `o_value`=0x80. "255",LF → 0xFF. "0",CR → 0x00.
- Hex: "xA5",CR → `o_value`=0xA5. "Xf",LF → 0x0F. "x",CR → `o_error` pulse, `o_value` unchanged.
- Overflow:
  - "256",CR → `o_error`, `o_value` retains its prior value.
  - "1000",CR → `o_error`.
  - "x123",CR → `o_error`.
  - In every case exactly one pulse, and it comes at the terminator.
- Invalid/recovery: "1g2",CR then "42",CR → `o_error`, then `o_valid` with 0x2A. CR,LF,CR alone → no pulses. `ACCEPT_SPACE`=0 with "12",space,CR → `o_error`.
- Timing gaps: "9" and "9" separated by 5 idle cycles, then CR → `o_value`=0x63; `o_busy` stays high throughout the gap.
- Reset mid-token: "x3", then assert `i_rst` while `i_rxValid`=1 with 'F', then CR → no pulses, `o_value`=0x00, `o_busy`=0.

Source files
------------

// File: rtl/ascii_byte_parser.sv
// ASCII number parser: turns a decimal ("0".."255") or x-prefixed hex ("x0".."xFF")
// character stream into an 8-bit value with one-cycle valid/error strobes.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | between tokens; terminators are silently ignored
//   DEC   | collecting decimal digits (cnt = digits seen, 1..3)
//   HEX   | prefix seen, collecting hex nibbles (cnt = 0..2)
//   ERR   | token rejected; swallow characters until a terminator
module ascii_byte_parser #(
    parameter int ACCEPT_SPACE = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rxValid,
    input  logic [7:0] i_rxByte,
    output logic [7:0] o_value,
    output logic       o_valid,
    output logic       o_error,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        HEX  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       busy_q;

    logic       is_dec;
    logic       is_hex_alpha;
    logic       is_hex;
    logic       is_pfx;
    logic       is_term;
    logic [3:0] nibble;
    logic [9:0] dec_next;

    // Character classification
    always_comb begin
        is_dec       = (i_rxByte >= 8'h30) && (i_rxByte <= 8'h39);
        is_hex_alpha = ((i_rxByte >= 8'h41) && (i_rxByte <= 8'h46)) ||
                       ((i_rxByte >= 8'h61) && (i_rxByte <= 8'h66));
        is_hex       = is_dec || is_hex_alpha;
        is_pfx       = (i_rxByte == 8'h78) || (i_rxByte == 8'h58);
        is_term      = (i_rxByte == 8'h0D) || (i_rxByte == 8'h0A) ||
                       ((ACCEPT_SPACE != 0) && (i_rxByte == 8'h20));
        // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
        nibble       = is_dec ? i_rxByte[3:0] : (i_rxByte[3:0] + 4'd9);
        // acc never exceeds 99 while cnt < 3, so 10 bits cannot wrap here
        dec_next     = (acc_q * 10'd10) + {6'd0, i_rxByte[3:0]};
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        valid_d = 1'b0;
        error_d = 1'b0;

        if (i_rxValid) begin
            unique case (state_q)
                IDLE: begin
                    if (is_dec) begin
                        acc_d   = {6'd0, i_rxByte[3:0]};
                        cnt_d   = 2'd1;
                        state_d = DEC;
                    end else if (is_pfx) begin
                        acc_d   = 10'd0;
                        cnt_d   = 2'd0;
                        state_d = HEX;
                    end else if (!is_term) begin
                        state_d = ERR;
                    end
                end

                DEC: begin
                    if (is_dec) begin
                        if ((cnt_q == 2'd3) || (dec_next > 10'd255)) begin
                            state_d = ERR;
                        end else begin
                            acc_d = dec_next;
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (is_term) begin
                        value_d = acc_q[7:0];
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ERR;
                    end
                end

                HEX: begin
                    if (is_hex) begin
                        if (cnt_q == 2'd2) begin
                            state_d = ERR;
                        end else begin
                            acc_d = {2'd0, acc_q[3:0], nibble};
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (is_term) begin
                        if (cnt_q == 2'd0) begin
                            error_d = 1'b1;
                        end else begin
                            value_d = acc_q[7:0];
                            valid_d = 1'b1;
                        end
                        state_d = IDLE;
                    end else begin
                        state_d = ERR;
                    end
                end

                ERR: begin
                    if (is_term) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= 10'd0;
            cnt_q   <= 2'd0;
            value_q <= 8'h00;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            valid_q <= valid_d;
            error_q <= error_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_value = value_q;
    assign o_valid = valid_q;
    assign o_error = error_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_ascii_byte_parser.sv
// Directed bench for ascii_byte_parser; a second instance with ACCEPT_SPACE=0
// sees the same stream so the space-terminator behaviour can be compared.
module tb_ascii_byte_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;

    logic [7:0] value, value0;
    logic       valid, valid0;
    logic       error, error0;
    logic       busy, busy0;

    int tests = 0;
    int fails = 0;
    int nv = 0, ne = 0, nv0 = 0, ne0 = 0;
    int both_seen = 0;
    int bv, be, bv0, be0;

    ascii_byte_parser #(.ACCEPT_SPACE(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rxValid(rx_valid), .i_rxByte(rx_byte),
        .o_value(value), .o_valid(valid), .o_error(error), .o_busy(busy)
    );

    ascii_byte_parser #(.ACCEPT_SPACE(0)) dut_nospace (
        .i_clk(clk), .i_rst(rst), .i_rxValid(rx_valid), .i_rxByte(rx_byte),
        .o_value(value0), .o_valid(valid0), .o_error(error0), .o_busy(busy0)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1)  nv++;
        if (error === 1'b1)  ne++;
        if (valid0 === 1'b1) nv0++;
        if (error0 === 1'b1) ne0++;
        if ((valid === 1'b1 && error === 1'b1) || (valid0 === 1'b1 && error0 === 1'b1))
            both_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark;
        bv = nv; be = ne; bv0 = nv0; be0 = ne0;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        idle(3);
        rst = 1'b0;
        chk("rst_value", value, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_busy",  busy,  1'b0);

        // "128" CR
        mark();
        send("1");
        chk("dec128_busy_rise", busy, 1'b1);
        send_str("28");
        chk("dec128_no_early_pulse", valid, 1'b0);
        send(8'h0D);
        chk("dec128_valid", valid, 1'b1);
        chk("dec128_value", value, 8'h80);
        chk("dec128_busy_fall", busy, 1'b0);
        idle(1);
        chk("dec128_pulse_width", valid, 1'b0);
        chk("dec128_nvalid", nv - bv, 1);

        // "255" LF, "0" CR
        send_str("255"); send(8'h0A);
        chk("dec255_valid", valid, 1'b1);
        chk("dec255_value", value, 8'hFF);
        send("0"); send(8'h0D);
        chk("dec0_valid", valid, 1'b1);
        chk("dec0_value", value, 8'h00);

        // hex
        send_str("xA5"); send(8'h0D);
        chk("hexA5_valid", valid, 1'b1);
        chk("hexA5_value", value, 8'hA5);
        send_str("Xf"); send(8'h0A);
        chk("hexXf_valid", valid, 1'b1);
        chk("hexXf_value", value, 8'h0F);
        idle(1);

        mark();
        send("x"); send(8'h0D);
        chk("barex_error", error, 1'b1);
        chk("barex_novalid", valid, 1'b0);
        chk("barex_value", value, 8'h0F);
        idle(2);
        chk("barex_nerror", ne - be, 1);

        // overflow cases: one error, exactly at the terminator
        mark();
        send_str("256");
        chk("ovf256_no_early", error, 1'b0);
        send(8'h0D);
        chk("ovf256_error", error, 1'b1);
        chk("ovf256_value", value, 8'h0F);
        send_str("1000");
        chk("ovf1000_no_early", error, 1'b0);
        send(8'h0D);
        chk("ovf1000_error", error, 1'b1);
        send_str("x123");
        chk("ovfx123_no_early", error, 1'b0);
        send(8'h0D);
        chk("ovfx123_error", error, 1'b1);
        idle(2);
        chk("ovf_nerror", ne - be, 3);
        chk("ovf_nvalid", nv - bv, 0);

        // leading zeros
        send_str("007"); send(8'h0D);
        chk("dec007_valid", valid, 1'b1);
        chk("dec007_value", value, 8'h07);
        send_str("0007"); send(8'h0D);
        chk("dec0007_error", error, 1'b1);
        chk("dec0007_value", value, 8'h07);

        // invalid then recovery
        send_str("1g2"); send(8'h0D);
        chk("inv1g2_error", error, 1'b1);
        send_str("42"); send(8'h0D);
        chk("rec42_valid", valid, 1'b1);
        chk("rec42_value", value, 8'h2A);
        idle(1);

        // blank terminators are silent
        mark();
        send(8'h0D); send(8'h0A); send(8'h0D);
        chk("blank_busy", busy, 1'b0);
        idle(2);
        chk("blank_nvalid", nv - bv, 0);
        chk("blank_nerror", ne - be, 0);

        // space terminator: accepted by dut, invalid for dut_nospace
        mark();
        send_str("12"); send(8'h20);
        chk("space_valid", valid, 1'b1);
        chk("space_value", value, 8'h0C);
        chk("nospace_no_pulse", valid0 | error0, 1'b0);
        chk("nospace_busy", busy0, 1'b1);
        send(8'h0D);
        chk("nospace_error", error0, 1'b1);
        chk("space_cr_silent", valid | error, 1'b0);
        chk("nospace_value", value0, 8'h2A);
        idle(2);
        chk("space_nvalid", nv - bv, 1);
        chk("nospace_nerror", ne0 - be0, 1);
        chk("nospace_nvalid", nv0 - bv0, 0);

        // back-to-back tokens, digit right after terminator
        send("5"); send(8'h0D);
        chk("b2b5_value", value, 8'h05);
        send("7");
        chk("b2b7_busy", busy, 1'b1);
        send(8'h0D);
        chk("b2b7_valid", valid, 1'b1);
        chk("b2b7_value", value, 8'h07);

        // idle gap inside a token
        send("9");
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("gap_busy", busy, 1'b1);
        end
        send("9"); send(8'h0D);
        chk("gap_valid", valid, 1'b1);
        chk("gap_value", value, 8'h63);
        idle(1);

        // reset mid-token, reset wins over a valid character
        mark();
        send_str("x3");
        chk("rstmid_busy_before", busy, 1'b1);
        rst = 1'b1; rx_valid = 1'b1; rx_byte = "F";
        @(posedge clk); #1;
        rst = 1'b0; rx_valid = 1'b0;
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_value", value, 8'h00);
        send(8'h0D);
        chk("rstmid_cr_silent", valid | error, 1'b0);
        chk("rstmid_value_after", value, 8'h00);
        idle(2);
        chk("rstmid_npulses", (nv - bv) + (ne - be), 0);

        chk("never_both", both_seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
